oc_wormhole_arbiter: RTL and testbench
======================================

Name: oc_wormhole_arbiter

Overview:
- Per-output-channel arbiter for the mesh NoC switch; one instance per output port (RESOURCE, LEFT, NORTH, RIGHT, SOUTH).
- Collects the per-input routing decisions that target its output and grants the output to one input at a time, using round-robin fairness.
- Holds the grant for a whole wormhole packet, from head flit to tail flit.
- Drives the select of the output crossbar mux and tells the winning input when its flit has been transferred.

Parameters:
- IN_N, 5, number of input channels that can request this output.
- SEL_W, 3, width of the binary select; must satisfy 2^SEL_W >= IN_N.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- req_i  input  IN_N  req_i[k] = input k holds a valid flit whose routed oc_sel selects this output.
- head_i  input  IN_N  head_i[k] = the flit at input k is a head flit; valid only when req_i[k]=1.
- tail_i  input  IN_N  tail_i[k] = the flit at input k is a tail flit; head and tail both set = single-flit packet.
- oc_ready_i  input  1  downstream (next switch input buffer or resource) can accept a flit this cycle.
- grant_o  output  IN_N  one-hot registered grant, all zero when idle.
- sel_o  output  SEL_W  binary index of the granted input, for the crossbar mux; 0 when idle.
- xfer_o  output  IN_N  xfer_o[k] = a flit from input k is transferred this cycle (combinational); used to pop the input FIFO.
- oc_valid_o  output  1  OR of xfer_o; drives the output channel valid.
- busy_o  output  1  1 while in LOCKED.

Behaviour:
- Reset (rst_ni=0 at clock edge):
  - state=IDLE, ptr=0.
  - grant_o=0, sel_o=0, busy_o=0.
  - xfer_o and oc_valid_o are 0 because grant_o=0.
  - Reset takes effect mid-packet as well; the packet is abandoned and the input side must flush.
- States: IDLE, LOCKED.
- Eligibility in IDLE: input k is eligible when req_i[k] & head_i[k].
  - Requests from non-head flits are ignored in IDLE; they are never granted.
- IDLE with at least one eligible input:
  - Winner = first eligible index scanning ptr, ptr+1, ..., IN_N-1, 0, ..., ptr-1.
  - Next cycle: state=LOCKED, grant_o=onehot(winner), sel_o=winner, busy_o=1.
  - Arbitration therefore costs 1 cycle; the first transfer can occur at the earliest 1 cycle after the head first requests.
- IDLE with no eligible input: remain IDLE, outputs 0, ptr unchanged.
- Transfer rule, LOCKED only: xfer_o[k] = grant_o[k] & req_i[k] & oc_ready_i.
  - Zero-cycle combinational path from req_i and oc_ready_i to xfer_o.
- LOCKED, transfer without tail: stay LOCKED, grant unchanged.
- LOCKED, transfer with tail_i[g]=1:
  - Next cycle: state=IDLE, grant_o=0, sel_o=0, busy_o=0.
  - ptr = g+1, wrapping to 0 when g=IN_N-1.
- LOCKED, granted input has no request, or oc_ready_i=0: hold; no transfer, no timeout.
- Requests from other inputs during LOCKED are ignored; they do not affect ptr.
- No back-to-back grants: after a tail there is always at least one IDLE cycle before the next grant.
  - Peak throughput is 1 flit/cycle within a packet.
- A single-flit packet (head & tail) costs 2 cycles minimum: 1 arbitration + 1 transfer.
- ptr updates only on tail transfer, so every eligible input is granted within IN_N packets (starvation-free).
- Requests with out-of-range index are impossible by width; invariant: grant_o is one-hot or zero; assert in simulation.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles with req_i=5'b11111 and head_i=5'b11111 -> grant_o=0, sel_o=0, busy_o=0, xfer_o=0 throughout.
- Single packet: input 2 sends a 3-flit packet (head, body, tail), oc_ready_i=1 -> grant_o=5'b00100 and sel_o=2 one cycle after the head request; xfer_o[2] high for 3 consecutive cycles; IDLE on the following cycle; ptr=3.
- Round-robin fairness: inputs 0, 1 and 4 continuously send single-flit packets -> grant order 0, 1, 4, 0, 1, 4; each packet occupies 2 cycles.
- Wrap-around: ptr=4 (after input 3 wins), inputs 4 and 0 request -> input 4 wins, then input 0.
- Backpressure and lock: input 1 is LOCKED mid-packet, oc_ready_i=0 for 3 cycles while input 3 requests a head -> grant_o stays 5'b00010 and xfer_o=0; after oc_ready_i=1, input 1 finishes its tail before input 3 is granted.
- Non-head and reset mid-packet:
  - In IDLE, req_i[2]=1 with head_i[2]=0 -> no grant.
  - While LOCKED on input 0, rst_ni=0 for 1 cycle -> next cycle IDLE, grant_o=0, ptr=0.

Source files
------------

// File: rtl/oc_wormhole_arbiter_if.sv
// Request/grant bundle between the per-input routing logic and one output-channel arbiter.
// Handshake: a flit moves from input k when xfer_o[k]=1, i.e. grant_o[k] & req_i[k] & oc_ready_i.
interface oc_wormhole_arbiter_if #(
    parameter int IN_N  = 5,
    parameter int SEL_W = 3
);
    logic [IN_N-1:0]  req_i;
    logic [IN_N-1:0]  head_i;
    logic [IN_N-1:0]  tail_i;
    logic             oc_ready_i;
    logic [IN_N-1:0]  grant_o;
    logic [SEL_W-1:0] sel_o;
    logic [IN_N-1:0]  xfer_o;
    logic             oc_valid_o;
    logic             busy_o;
    logic             dbg_state_o;
    logic [SEL_W-1:0] dbg_ptr_o;

    modport slave (
        input  req_i, head_i, tail_i, oc_ready_i,
        output grant_o, sel_o, xfer_o, oc_valid_o, busy_o, dbg_state_o, dbg_ptr_o
    );

    modport master (
        output req_i, head_i, tail_i, oc_ready_i,
        input  grant_o, sel_o, xfer_o, oc_valid_o, busy_o, dbg_state_o, dbg_ptr_o
    );
endinterface

// File: rtl/oc_wormhole_arbiter.sv
// Round-robin output-channel arbiter that locks the output to one input for a whole
// wormhole packet (head to tail) and drives the crossbar select and per-input pop strobes.
module oc_wormhole_arbiter #(
    parameter int IN_N  = 5,
    parameter int SEL_W = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    oc_wormhole_arbiter_if.slave   bus
);
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [IN_N-1:0]  r_grant;
    logic [IN_N-1:0]  w_grant_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [IN_N-1:0]  w_elig;
    logic [SEL_W-1:0] w_win;
    logic [IN_N-1:0]  w_xfer;
    logic             w_tail_xfer;

    // First eligible index scanning ptr, ptr+1, ... with wrap at IN_N.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [IN_N-1:0]  elig,
                                                 input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] pick;
        logic             found;
        int               j;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < IN_N; i++) begin
            j = int'(ptr) + i;
            if (j >= IN_N) j = j - IN_N;
            if (!found && elig[j]) begin
                pick  = SEL_W'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        w_elig      = bus.req_i & bus.head_i;
        w_win       = rr_pick(w_elig, r_ptr);
        w_xfer      = (r_state == ST_LOCKED) ? (r_grant & bus.req_i & {IN_N{bus.oc_ready_i}})
                                             : '0;
        w_tail_xfer = |(w_xfer & bus.tail_i);

        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (|w_elig) begin
                    w_state_nxt = ST_LOCKED;
                    w_grant_nxt = IN_N'(1) << w_win;
                    w_sel_nxt   = w_win;
                end
            end
            ST_LOCKED: begin
                // Pointer only advances on tail transfer, which is what bounds starvation.
                if (w_tail_xfer) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_sel_nxt   = '0;
                    w_ptr_nxt   = (r_sel == SEL_W'(IN_N - 1)) ? '0 : r_sel + SEL_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_sel_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert ($onehot0(r_grant))
                else $error("grant_o not one-hot or zero: %b", r_grant);
        end
    end
`endif

    assign bus.grant_o     = r_grant;
    assign bus.sel_o       = r_sel;
    assign bus.xfer_o      = w_xfer;
    assign bus.oc_valid_o  = |w_xfer;
    assign bus.busy_o      = (r_state == ST_LOCKED);
    assign bus.dbg_state_o = r_state;
    assign bus.dbg_ptr_o   = r_ptr;
endmodule

// File: tb/tb_oc_wormhole_arbiter.sv
// Directed bench for oc_wormhole_arbiter: reset, single packet, round-robin order,
// wrap-around, backpressure lock, non-head requests and reset mid-packet.
module tb_oc_wormhole_arbiter;
    localparam int IN_N  = 5;
    localparam int SEL_W = 3;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [SEL_W-1:0] exp_q[$];

    oc_wormhole_arbiter_if #(.IN_N(IN_N), .SEL_W(SEL_W)) bus ();

    oc_wormhole_arbiter #(.IN_N(IN_N), .SEL_W(SEL_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [IN_N-1:0] req, input logic [IN_N-1:0] head,
                         input logic [IN_N-1:0] tail, input logic rdy);
        bus.req_i      = req;
        bus.head_i     = head;
        bus.tail_i     = tail;
        bus.oc_ready_i = rdy;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"}, 32'(bus.grant_o), 32'h0);
        check({tag, "_sel"},   32'(bus.sel_o),   32'h0);
        check({tag, "_busy"},  32'(bus.busy_o),  32'h0);
        check({tag, "_xfer"},  32'(bus.xfer_o),  32'h0);
    endtask

    initial begin
        logic [SEL_W-1:0] g;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive(5'b11111, 5'b11111, 5'b00000, 1'b1);

        // reset held 2 cycles with all heads requesting
        tick();
        check_idle("rst_c1");
        tick();
        check_idle("rst_c2");
        check("rst_ptr", 32'(bus.dbg_ptr_o), 32'd0);
        rst_n = 1'b1;
        drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
        tick();
        check_idle("post_rst");

        // single 3-flit packet from input 2
        drive(5'b00100, 5'b00100, 5'b00000, 1'b1);
        check("pkt_arb_grant", 32'(bus.grant_o), 32'h0);
        check("pkt_arb_xfer",  32'(bus.xfer_o),  32'h0);
        tick();
        check("pkt_grant",  32'(bus.grant_o), 32'h04);
        check("pkt_sel",    32'(bus.sel_o),   32'd2);
        check("pkt_busy",   32'(bus.busy_o),  32'd1);
        check("pkt_xfer_h", 32'(bus.xfer_o),  32'h04);
        tick();
        drive(5'b00100, 5'b00000, 5'b00000, 1'b1);
        check("pkt_xfer_b", 32'(bus.xfer_o),  32'h04);
        tick();
        drive(5'b00100, 5'b00000, 5'b00100, 1'b1);
        check("pkt_xfer_t", 32'(bus.xfer_o),  32'h04);
        check("pkt_valid",  32'(bus.oc_valid_o), 32'd1);
        tick();
        drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
        check_idle("pkt_done");
        check("pkt_ptr", 32'(bus.dbg_ptr_o), 32'd3);

        // round robin from ptr=0 over inputs 0,1,4 sending single-flit packets
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rr_ptr0", 32'(bus.dbg_ptr_o), 32'd0);
        exp_q = '{3'd0, 3'd1, 3'd4, 3'd0, 3'd1, 3'd4};
        drive(5'b10011, 5'b10011, 5'b10011, 1'b1);
        while (exp_q.size() > 0) begin
            g = exp_q.pop_front();
            check("rr_idle_busy", 32'(bus.busy_o), 32'd0);
            check("rr_idle_xfer", 32'(bus.xfer_o), 32'h0);
            tick();
            check("rr_grant", 32'(bus.grant_o), 32'(5'b00001 << g));
            check("rr_sel",   32'(bus.sel_o),   32'(g));
            check("rr_xfer",  32'(bus.xfer_o),  32'(5'b00001 << g));
            tick();
        end
        check("rr_ptr_wrap", 32'(bus.dbg_ptr_o), 32'd0);

        // wrap-around: input 3 wins, ptr=4, then 4 beats 0, then 0
        drive(5'b01000, 5'b01000, 5'b01000, 1'b1);
        tick();
        check("wr_grant3", 32'(bus.grant_o), 32'h08);
        tick();
        check("wr_ptr4", 32'(bus.dbg_ptr_o), 32'd4);
        drive(5'b10001, 5'b10001, 5'b10001, 1'b1);
        tick();
        check("wr_grant4", 32'(bus.grant_o), 32'h10);
        check("wr_sel4",   32'(bus.sel_o),   32'd4);
        tick();
        check("wr_ptr0", 32'(bus.dbg_ptr_o), 32'd0);
        tick();
        check("wr_grant0", 32'(bus.grant_o), 32'h01);
        tick();
        drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
        check("wr_ptr1", 32'(bus.dbg_ptr_o), 32'd1);

        // backpressure: input 1 locked, ready low 3 cycles, input 3 waits
        drive(5'b00010, 5'b00010, 5'b00000, 1'b1);
        tick();
        check("bp_grant", 32'(bus.grant_o), 32'h02);
        check("bp_xfer_h", 32'(bus.xfer_o), 32'h02);
        tick();
        drive(5'b01010, 5'b01000, 5'b01010, 1'b0);
        for (int c = 0; c < 3; c++) begin
            check("bp_hold_grant", 32'(bus.grant_o), 32'h02);
            check("bp_hold_xfer",  32'(bus.xfer_o),  32'h0);
            check("bp_hold_valid", 32'(bus.oc_valid_o), 32'd0);
            if (c < 2) tick();
        end
        tick();
        drive(5'b01010, 5'b01000, 5'b01010, 1'b1);
        check("bp_tail_grant", 32'(bus.grant_o), 32'h02);
        check("bp_tail_xfer",  32'(bus.xfer_o),  32'h02);
        tick();
        check_idle("bp_gap");
        check("bp_ptr2", 32'(bus.dbg_ptr_o), 32'd2);
        tick();
        check("bp_grant3", 32'(bus.grant_o), 32'h08);
        check("bp_xfer3",  32'(bus.xfer_o),  32'h08);
        tick();
        drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
        check("bp_ptr4", 32'(bus.dbg_ptr_o), 32'd4);

        // non-head request in IDLE is never granted
        drive(5'b00100, 5'b00000, 5'b00000, 1'b1);
        tick();
        check_idle("nh_c1");
        tick();
        check_idle("nh_c2");
        check("nh_ptr", 32'(bus.dbg_ptr_o), 32'd4);

        // reset mid-packet while locked on input 0
        drive(5'b00001, 5'b00001, 5'b00000, 1'b1);
        tick();
        check("mr_grant0", 32'(bus.grant_o), 32'h01);
        tick();
        drive(5'b00001, 5'b00000, 5'b00000, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle("mr_rst");
        check("mr_ptr", 32'(bus.dbg_ptr_o), 32'd0);
        check("mr_state", 32'(bus.dbg_state_o), 32'd0);
        tick();
        check_idle("mr_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
